// File: rtl/melody_pkg.sv
// melody_pkg: shared definitions for the melody player.
//   - state_e       : playback FSM state encoding
//   - PITCH_REST    : pitch code of an explicit rest
//   - DUR_END       : duration code marking the end of a tune
//   - DEFAULT_SONG  : C-major scale up and down, one beat per note, then end marker
//   - pitch_to_key  : pitch code -> one-hot KEY bus (MSB = low C)
package melody_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_PLAY   = 3'd2,
      ST_GAP    = 3'd3,
      ST_FINISH = 3'd4
   } state_e;

   localparam logic [3:0] PITCH_REST = 4'd0;
   localparam logic [3:0] DUR_END    = 4'd0;

   // Entry i lives in bits [8*i +: 8]; entry 0 (0x11 = C4, 1 beat) is the LSB byte.
   localparam logic [511:0] DEFAULT_SONG =
      {384'h0, 128'h00112131415161718171615141312111};

   // Pitches 1..8 select C4..C5; 0 and the unused codes 9..15 are silent.
   function automatic logic [7:0] pitch_to_key(input logic [3:0] pitch);
      logic [7:0] key;
      if (pitch != PITCH_REST && pitch <= 4'd8) begin
         key = 8'h80 >> (pitch - 4'd1);
      end else begin
         key = 8'h00;
      end
      return key;
   endfunction

endpackage

// File: rtl/melody_rom.sv
// melody_rom: fixed note table, combinational read.
//   idx_i   in  6  table index
//   entry_o out 8  {pitch[3:0], dur[3:0]}
module melody_rom
   import melody_pkg::*;
#(
   parameter logic [511:0] SONG_TABLE = DEFAULT_SONG
) (
   input  logic [5:0] idx_i,
   output logic [7:0] entry_o
);

   assign entry_o = SONG_TABLE[{idx_i, 3'b000} +: 8];

endmodule

// File: rtl/melody_player.sv
// melody_player: autonomous tune sequencer in front of the piezo tone generator.
//   clk_i       in  1  system clock
//   resetn_i    in  1  synchronous active-low reset
//   start_i     in  1  start playback from entry 0 (IDLE only)
//   stop_i      in  1  abort playback, priority over start_i
//   loop_i      in  1  at end of tune: restart instead of finishing
//   key_in_i    in  8  manual keypad, passed through while idle
//   key_o       out 8  one-hot note to the tone generator (registered)
//   busy_o      out 1  high whenever not idle
//   done_o      out 1  one-cycle pulse when a tune ends without looping
//   note_idx_o  out 6  current table index
module melody_player
   import melody_pkg::*;
#(
   parameter int unsigned  TICK_DIV   = 5_000_000,
   parameter int unsigned  GAP_CYC    = 500_000,
   parameter int unsigned  SONG_LEN   = 32,
   parameter logic [511:0] SONG_TABLE = DEFAULT_SONG
) (
   input  logic       clk_i,
   input  logic       resetn_i,
   input  logic       start_i,
   input  logic       stop_i,
   input  logic       loop_i,
   input  logic [7:0] key_in_i,
   output logic [7:0] key_o,
   output logic       busy_o,
   output logic       done_o,
   output logic [5:0] note_idx_o
);

   localparam logic [27:0] TICK_W   = 28'(TICK_DIV);
   localparam logic [23:0] GAP_W    = 24'(GAP_CYC);
   localparam logic [5:0]  LAST_IDX = 6'(SONG_LEN - 1);

   state_e      state_q, state_d;
   logic [5:0]  idx_q, idx_d;
   logic [27:0] cnt_q, cnt_d;
   logic [23:0] gap_q, gap_d;
   logic [7:0]  key_q, key_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [7:0]  entry_s;
   logic        note_over_s;

   melody_rom #(.SONG_TABLE(SONG_TABLE)) u_rom (
      .idx_i   (idx_q),
      .entry_o (entry_s)
   );

   // Next-state, counters and next output values.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      gap_d       = gap_q;
      note_over_s = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start_i && !stop_i) begin
               state_d = ST_LOAD;
               idx_d   = 6'd0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOAD: begin
            if (entry_s[3:0] == DUR_END) begin
               state_d = ST_FINISH;
            end else begin
               state_d = ST_PLAY;
               cnt_d   = 28'(entry_s[3:0]) * TICK_W - 28'd1;
            end
         end
         ST_PLAY: begin
            if (cnt_q != 28'd0) begin
               cnt_d = cnt_q - 28'd1;
            end else if (GAP_W != 24'd0) begin
               state_d = ST_GAP;
               gap_d   = GAP_W - 24'd1;
            end else begin
               note_over_s = 1'b1;
            end
         end
         ST_GAP: begin
            if (gap_q != 24'd0) begin
               gap_d = gap_q - 24'd1;
            end else begin
               note_over_s = 1'b1;
            end
         end
         ST_FINISH: begin
            // done_q was raised on entry only when LOOP was low, so it doubles
            // as the remembered loop decision.
            idx_d = 6'd0;
            if (done_q) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_LOAD;
            end
         end
         default: begin
            state_d = ST_IDLE;
            idx_d   = 6'd0;
         end
      endcase

      if (note_over_s) begin
         if (idx_q == LAST_IDX) begin
            state_d = ST_FINISH;
         end else begin
            state_d = ST_LOAD;
            idx_d   = idx_q + 6'd1;
         end
      end else begin
         idx_d = idx_d;
      end

      if (stop_i && state_q != ST_IDLE) begin
         state_d = ST_IDLE;
         idx_d   = 6'd0;
         cnt_d   = 28'd0;
         gap_d   = 24'd0;
      end else begin
         cnt_d = cnt_d;
      end

      // KEY follows the state being entered so the register lines up with it;
      // the first idle cycle after playback is silent, not keypad.
      case (state_d)
         ST_IDLE:  key_d = (state_q == ST_IDLE) ? key_in_i : 8'h00;
         ST_PLAY:  key_d = pitch_to_key(entry_s[7:4]);
         default:  key_d = 8'h00;
      endcase

      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_FINISH) && !loop_i;
   end

   // State, counter and output registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (!resetn_i) begin
         state_q <= ST_IDLE;
         idx_q   <= 6'd0;
         cnt_q   <= 28'd0;
         gap_q   <= 24'd0;
         key_q   <= 8'h00;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         gap_q   <= gap_d;
         key_q   <= key_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign key_o      = key_q;
   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign note_idx_o = idx_q;

endmodule

// File: tb/tb_melody_player.sv
// tb_melody_player: directed self-checking bench for melody_player.
// Four instances share the inputs, each with its own note table:
//   seq  : {0x11, 0x82, 0x00}
//   rest : {0x03, 0x00}
//   lp   : {0x11, 0x21}, SONG_LEN=2
//   def  : default scale table
module tb_melody_player;

   logic       clk;
   logic       resetn;
   logic       start;
   logic       stop;
   logic       loop_in;
   logic [7:0] key_in;

   logic [7:0] seq_key,  rest_key,  lp_key,  def_key;
   logic       seq_busy, rest_busy, lp_busy, def_busy;
   logic       seq_done, rest_done, lp_done, def_done;
   logic [5:0] seq_idx,  rest_idx,  lp_idx,  def_idx;

   int n_checks = 0;
   int n_fail   = 0;

   melody_player #(.TICK_DIV(4), .GAP_CYC(2), .SONG_LEN(3),
                   .SONG_TABLE({488'h0, 24'h008211})) u_seq (
      .clk_i(clk), .resetn_i(resetn), .start_i(start), .stop_i(stop),
      .loop_i(loop_in), .key_in_i(key_in), .key_o(seq_key),
      .busy_o(seq_busy), .done_o(seq_done), .note_idx_o(seq_idx));

   melody_player #(.TICK_DIV(4), .GAP_CYC(2), .SONG_LEN(2),
                   .SONG_TABLE({496'h0, 16'h0003})) u_rest (
      .clk_i(clk), .resetn_i(resetn), .start_i(start), .stop_i(stop),
      .loop_i(loop_in), .key_in_i(key_in), .key_o(rest_key),
      .busy_o(rest_busy), .done_o(rest_done), .note_idx_o(rest_idx));

   melody_player #(.TICK_DIV(4), .GAP_CYC(2), .SONG_LEN(2),
                   .SONG_TABLE({496'h0, 16'h2111})) u_lp (
      .clk_i(clk), .resetn_i(resetn), .start_i(start), .stop_i(stop),
      .loop_i(loop_in), .key_in_i(key_in), .key_o(lp_key),
      .busy_o(lp_busy), .done_o(lp_done), .note_idx_o(lp_idx));

   melody_player #(.TICK_DIV(4), .GAP_CYC(2), .SONG_LEN(32)) u_def (
      .clk_i(clk), .resetn_i(resetn), .start_i(start), .stop_i(stop),
      .loop_i(loop_in), .key_in_i(key_in), .key_o(def_key),
      .busy_o(def_busy), .done_o(def_done), .note_idx_o(def_idx));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      resetn  = 1'b0;
      start   = 1'b0;
      stop    = 1'b0;
      loop_in = 1'b0;
      key_in  = 8'h00;
      tick();
      tick();
      resetn = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      n_checks++; if (def_key !== 8'h00) begin n_fail++; $display("FAIL reset_key got %h want 00", def_key); end
      n_checks++; if (def_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", def_busy); end
      n_checks++; if (def_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", def_done); end
      n_checks++; if (def_idx !== 6'd0) begin n_fail++; $display("FAIL reset_idx got %0d want 0", def_idx); end
   endtask

   task automatic test_reset_mid_play();
      apply_reset();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int t = 2; t <= 17; t++) tick();
      n_checks++; if (def_key !== 8'h20) begin n_fail++; $display("FAIL midplay_key got %h want 20", def_key); end
      n_checks++; if (def_idx !== 6'd2) begin n_fail++; $display("FAIL midplay_idx got %0d want 2", def_idx); end
      resetn = 1'b0;
      tick();
      n_checks++; if (def_key !== 8'h00) begin n_fail++; $display("FAIL rstplay_key got %h want 00", def_key); end
      n_checks++; if (def_busy !== 1'b0) begin n_fail++; $display("FAIL rstplay_busy got %b want 0", def_busy); end
      n_checks++; if (def_idx !== 6'd0) begin n_fail++; $display("FAIL rstplay_idx got %0d want 0", def_idx); end
      resetn = 1'b1;
      start  = 1'b1;
      tick();
      start = 1'b0;
      n_checks++; if (def_busy !== 1'b1) begin n_fail++; $display("FAIL replay_busy got %b want 1", def_busy); end
      n_checks++; if (def_key !== 8'h00) begin n_fail++; $display("FAIL replay_load_key got %h want 00", def_key); end
      tick();
      n_checks++; if (def_key !== 8'h80) begin n_fail++; $display("FAIL replay_key got %h want 80", def_key); end
      n_checks++; if (def_idx !== 6'd0) begin n_fail++; $display("FAIL replay_idx got %0d want 0", def_idx); end
   endtask

   task automatic test_sequence();
      logic [7:0] exp_key;
      logic [5:0] exp_idx;
      apply_reset();
      start = 1'b1;
      for (int t = 1; t <= 21; t++) begin
         tick();
         start   = 1'b0;
         exp_key = (t >= 2 && t <= 5) ? 8'h80 : ((t >= 9 && t <= 16) ? 8'h01 : 8'h00);
         exp_idx = (t <= 7) ? 6'd0 : ((t <= 18) ? 6'd1 : 6'd2);
         n_checks++; if (seq_key !== exp_key) begin n_fail++; $display("FAIL seq_key t=%0d got %h want %h", t, seq_key, exp_key); end
         n_checks++; if (seq_busy !== (t <= 20)) begin n_fail++; $display("FAIL seq_busy t=%0d got %b want %b", t, seq_busy, (t <= 20)); end
         n_checks++; if (seq_done !== (t == 20)) begin n_fail++; $display("FAIL seq_done t=%0d got %b want %b", t, seq_done, (t == 20)); end
         if (t <= 20) begin
            n_checks++; if (seq_idx !== exp_idx) begin n_fail++; $display("FAIL seq_idx t=%0d got %0d want %0d", t, seq_idx, exp_idx); end
         end
      end
   endtask

   task automatic test_back_to_back();
      apply_reset();
      start = 1'b1;
      for (int t = 1; t <= 23; t++) begin
         tick();
         if (t == 20) begin
            n_checks++; if (seq_done !== 1'b1) begin n_fail++; $display("FAIL b2b_done got %b want 1", seq_done); end
         end
         if (t == 21) begin
            n_checks++; if (seq_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got %b want 0", seq_busy); end
         end
         if (t == 22) begin
            n_checks++; if (seq_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_restart got %b want 1", seq_busy); end
         end
         if (t == 23) begin
            n_checks++; if (seq_key !== 8'h80) begin n_fail++; $display("FAIL b2b_key got %h want 80", seq_key); end
         end
      end
      start = 1'b0;
   endtask

   task automatic test_rest();
      apply_reset();
      start = 1'b1;
      for (int t = 1; t <= 18; t++) begin
         tick();
         start = 1'b0;
         n_checks++; if (rest_key !== 8'h00) begin n_fail++; $display("FAIL rest_key t=%0d got %h want 00", t, rest_key); end
         n_checks++; if (rest_busy !== (t <= 17)) begin n_fail++; $display("FAIL rest_busy t=%0d got %b want %b", t, rest_busy, (t <= 17)); end
         n_checks++; if (rest_done !== (t == 17)) begin n_fail++; $display("FAIL rest_done t=%0d got %b want %b", t, rest_done, (t == 17)); end
         if (t <= 15) begin
            n_checks++; if (rest_idx !== 6'd0) begin n_fail++; $display("FAIL rest_idx t=%0d got %0d want 0", t, rest_idx); end
         end
      end
   endtask

   task automatic test_stop();
      int dones;
      dones = 0;
      apply_reset();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int t = 2; t <= 17; t++) begin
         tick();
         dones += int'(def_done);
      end
      n_checks++; if (def_key !== 8'h20) begin n_fail++; $display("FAIL stop_third_key got %h want 20", def_key); end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      n_checks++; if (def_key !== 8'h00) begin n_fail++; $display("FAIL stop_key got %h want 00", def_key); end
      n_checks++; if (def_busy !== 1'b0) begin n_fail++; $display("FAIL stop_busy got %b want 0", def_busy); end
      n_checks++; if (def_idx !== 6'd0) begin n_fail++; $display("FAIL stop_idx got %0d want 0", def_idx); end
      for (int t = 0; t < 30; t++) begin
         tick();
         dones += int'(def_done);
      end
      n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL stop_no_done got %0d want 0", dones); end
      n_checks++; if (def_busy !== 1'b0) begin n_fail++; $display("FAIL stop_stays_idle got %b want 0", def_busy); end
      start = 1'b1;
      stop  = 1'b1;
      tick();
      n_checks++; if (def_busy !== 1'b0) begin n_fail++; $display("FAIL startstop_busy got %b want 0", def_busy); end
      tick();
      n_checks++; if (def_busy !== 1'b0) begin n_fail++; $display("FAIL startstop_busy2 got %b want 0", def_busy); end
      start = 1'b0;
      stop  = 1'b0;
   endtask

   task automatic test_loop();
      int         tp;
      int         dones;
      logic [7:0] exp_key;
      logic [5:0] exp_idx;
      dones = 0;
      apply_reset();
      loop_in = 1'b1;
      start   = 1'b1;
      for (int t = 1; t <= 64; t++) begin
         tick();
         start = 1'b0;
         dones += int'(lp_done);
         tp = (t - 1) % 15;
         exp_key = (tp >= 1 && tp <= 4) ? 8'h80 : ((tp >= 8 && tp <= 11) ? 8'h40 : 8'h00);
         exp_idx = (tp <= 6) ? 6'd0 : 6'd1;
         n_checks++; if (lp_done !== (t == 60)) begin n_fail++; $display("FAIL loop_done t=%0d got %b want %b", t, lp_done, (t == 60)); end
         n_checks++; if (lp_busy !== (t <= 60)) begin n_fail++; $display("FAIL loop_busy t=%0d got %b want %b", t, lp_busy, (t <= 60)); end
         if (t <= 60) begin
            n_checks++; if (lp_key !== exp_key) begin n_fail++; $display("FAIL loop_key t=%0d got %h want %h", t, lp_key, exp_key); end
            n_checks++; if (lp_idx !== exp_idx) begin n_fail++; $display("FAIL loop_idx t=%0d got %0d want %0d", t, lp_idx, exp_idx); end
         end
         if (t == 45) loop_in = 1'b0;
      end
      n_checks++; if (dones !== 1) begin n_fail++; $display("FAIL loop_done_count got %0d want 1", dones); end
   endtask

   task automatic test_pass_through();
      apply_reset();
      key_in = 8'h20;
      tick();
      n_checks++; if (def_key !== 8'h20) begin n_fail++; $display("FAIL pass_key got %h want 20", def_key); end
      key_in = 8'h04;
      tick();
      n_checks++; if (def_key !== 8'h04) begin n_fail++; $display("FAIL pass_key2 got %h want 04", def_key); end
      key_in = 8'h01;
      start  = 1'b1;
      tick();
      start = 1'b0;
      n_checks++; if (def_key !== 8'h00) begin n_fail++; $display("FAIL pass_load_key got %h want 00", def_key); end
      tick();
      n_checks++; if (def_key !== 8'h80) begin n_fail++; $display("FAIL pass_play_key got %h want 80", def_key); end
      key_in = 8'h02;
      tick();
      n_checks++; if (def_key !== 8'h80) begin n_fail++; $display("FAIL pass_ignored got %h want 80", def_key); end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      n_checks++; if (def_key !== 8'h00) begin n_fail++; $display("FAIL pass_stop_key got %h want 00", def_key); end
      tick();
      n_checks++; if (def_key !== 8'h02) begin n_fail++; $display("FAIL pass_resume got %h want 02", def_key); end
      key_in = 8'h00;
   endtask

   initial begin
      resetn  = 1'b0;
      start   = 1'b0;
      stop    = 1'b0;
      loop_in = 1'b0;
      key_in  = 8'h00;
      test_reset();
      test_reset_mid_play();
      test_sequence();
      test_back_to_back();
      test_rest();
      test_stop();
      test_loop();
      test_pass_through();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
